// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO timer/TX responder: register offsets
// (word index io_a[4:2]), STATUS/CONTROL bit positions and FSM states.
package mmio_pkg;

  localparam logic [2:0] REG_TXDATA  = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_COUNT   = 3'd2;
  localparam logic [2:0] REG_COMPARE = 3'd3;
  localparam logic [2:0] REG_CONTROL = 3'd4;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_IRQ     = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_OCC_LSB = 4;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IRQ_CLR = 1;
  localparam int unsigned CTRL_OVF_CLR = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// Ports: clk/rst (sync, active-high), push/wdata (dropped when full),
// pop (ignored when empty), rdata (combinational head, 0 when empty),
// full/empty, count (occupancy 0..DEPTH).
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/mmio_timer_tx_responder.sv
// MMIO responder: answers CPU I/O accesses after LATENCY wait cycles with a
// one-cycle io_ready strobe. Holds a 32-bit interval timer with sticky irq
// and a TX FIFO drained through tx_valid/tx_ready.
// Ports: clk, rst (sync, active-high); io_a/io_d_w/io_access/io_write in,
// io_d_r/io_ready out; tx_data/tx_valid out, tx_ready in; irq out.
module mmio_timer_tx_responder
  import mmio_pkg::*;
#(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_a,
  input  logic [31:0] io_d_w,
  output logic [31:0] io_d_r,
  input  logic        io_access,
  input  logic        io_write,
  output logic        io_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int unsigned WW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [2:0]      addr_q, addr_d;
  logic            write_q, write_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     compare_q, compare_d;
  logic            enable_q, enable_d;
  logic            irq_q, irq_d;
  logic            ovf_q, ovf_d;

  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     fifo_head;
  logic            resp, wr_en, push_req, hit;
  logic [31:0]     status, rd_data;
  logic            unused_io_a;

  assign unused_io_a = ^{io_a[31:5], io_a[1:0]};

  assign resp     = (state_q == ST_RESP);
  assign wr_en    = resp && write_q;
  assign push_req = wr_en && (addr_q == REG_TXDATA);
  assign hit      = enable_q && (count_q == compare_q);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (io_d_w),
    .pop   (tx_ready),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Access FSM; address and direction are captured when leaving IDLE.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    unique case (state_q)
      ST_IDLE: begin
        if (io_access) begin
          addr_d  = io_a[4:2];
          write_d = io_write;
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WW'(LATENCY);
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == WW'(1)) state_d = ST_RESP;
        else                  wcnt_d  = wcnt_q - WW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    status = '0;
    status[STAT_FULL]            = fifo_full;
    status[STAT_EMPTY]           = fifo_empty;
    status[STAT_IRQ]             = irq_q;
    status[STAT_OVF]             = ovf_q;
    status[STAT_OCC_LSB +: 4]    = 4'(fifo_count);
    case (addr_q)
      REG_STATUS:  rd_data = status;
      REG_COUNT:   rd_data = count_q;
      REG_COMPARE: rd_data = compare_q;
      REG_CONTROL: rd_data = {31'b0, enable_q};
      default:     rd_data = '0;
    endcase
  end

  // Timer and register writes. The CPU COUNT write is applied after the
  // timer update so it overrides it; flag sets are applied after the W1C
  // clears so a same-cycle set wins.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    enable_d  = enable_q;
    irq_d     = irq_q;
    ovf_d     = ovf_q;
    if (enable_q) count_d = hit ? '0 : count_q + 32'd1;
    if (wr_en) begin
      case (addr_q)
        REG_COUNT:   count_d   = io_d_w;
        REG_COMPARE: compare_d = io_d_w;
        REG_CONTROL: begin
          enable_d = io_d_w[CTRL_EN];
          if (io_d_w[CTRL_IRQ_CLR]) irq_d = 1'b0;
          if (io_d_w[CTRL_OVF_CLR]) ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (hit) irq_d = 1'b1;
    if (push_req && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      count_q   <= '0;
      compare_q <= '1;
      enable_q  <= 1'b0;
      irq_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      enable_q  <= enable_d;
      irq_q     <= irq_d;
      ovf_q     <= ovf_d;
    end
  end

  assign io_ready = resp;
  assign io_d_r   = (resp && !write_q) ? rd_data : '0;
  assign irq      = irq_q;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;

endmodule
